// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle MIPS control FSM
package ctrl_pkg;
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ILL = 3'd7
  } state_t;
  typedef enum logic [3:0] {
    C_R_ALU, C_I_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
  } class_t;
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL    = 6'h00;
  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_XOR    = 6'h26;
  localparam logic [5:0] F_NOR    = 6'h27;
  localparam logic [5:0] F_SLTU   = 6'h2B;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [1:0] PC_S_PC4 = 2'b00;
  localparam logic [1:0] PC_S_RS  = 2'b01;
  localparam logic [1:0] PC_S_BR  = 2'b10;
  localparam logic [1:0] PC_S_JMP = 2'b11;
  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  localparam logic [1:0] RD_RD    = 2'b00;
  localparam logic [1:0] RD_RT    = 2'b01;
  localparam logic [1:0] RD_31    = 2'b10;
endpackage

// File: rtl/inst_class_dec.sv
// inst_class_dec: combinational instruction class and ALU control decode
module inst_class_dec
  import ctrl_pkg::*;
(
  input  logic [31:0] Inst_code,
  output class_t      cls,
  output logic [3:0]  alu_op,
  output logic        rt_imm_s,
  output logic        imm_s
);
  logic [5:0] op, func;
  logic unused_bits;
  assign op = Inst_code[31:26];
  assign func = Inst_code[5:0];
  assign unused_bits = ^Inst_code[25:6];
  always_comb begin
    cls = C_ILL;
    alu_op = ALU_ADD;
    rt_imm_s = 1'b0;
    imm_s = 1'b0;
    case (op)
      OP_R: begin
        cls = C_R_ALU;
        case (func)
          F_ADD: alu_op = ALU_ADD;
          F_SUB: alu_op = ALU_SUB;
          F_AND: alu_op = ALU_AND;
          F_OR: alu_op = ALU_OR;
          F_XOR: alu_op = ALU_XOR;
          F_NOR: alu_op = ALU_NOR;
          F_SLTU: alu_op = ALU_SLTU;
          F_SLL: alu_op = ALU_SLL;
          F_JR: cls = C_JR;
          default: cls = C_ILL;
        endcase
      end
      OP_ADDI: begin cls = C_I_ALU; rt_imm_s = 1'b1; imm_s = 1'b1; end
      OP_ANDI: begin cls = C_I_ALU; rt_imm_s = 1'b1; alu_op = ALU_AND; end
      OP_XORI: begin cls = C_I_ALU; rt_imm_s = 1'b1; alu_op = ALU_XOR; end
      OP_SLTIU: begin cls = C_I_ALU; rt_imm_s = 1'b1; alu_op = ALU_SLTU; end
      OP_LW: begin cls = C_LW; rt_imm_s = 1'b1; imm_s = 1'b1; end
      OP_SW: begin cls = C_SW; rt_imm_s = 1'b1; imm_s = 1'b1; end
      OP_BEQ: begin cls = C_BEQ; alu_op = ALU_SUB; end
      OP_BNE: begin cls = C_BNE; alu_op = ALU_SUB; end
      OP_J: cls = C_J;
      OP_JAL: cls = C_JAL;
      default: cls = C_ILL;
    endcase
  end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS control FSM with retire counter
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [31:0]      Inst_code,
  input  logic             ZF,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IR_Write,
  output logic             Reg_Write,
  output logic             Mem_Write,
  output logic [3:0]       ALU_OP,
  output logic [1:0]       alu_mem_s,
  output logic             rt_imm_s,
  output logic             imm_s,
  output logic [1:0]       rd_rt_s,
  output logic [1:0]       PC_s,
  output logic [2:0]       state,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] inst_cnt
);
  state_t st;
  class_t cls;
  logic [3:0] dec_op;
  logic dec_rt_imm, dec_imm;
  logic fetch, jmp, jal, br, br_tk, exm, wb, sw_done;
  inst_class_dec u_dec (
    .Inst_code(Inst_code),
    .cls(cls),
    .alu_op(dec_op),
    .rt_imm_s(dec_rt_imm),
    .imm_s(dec_imm)
  );
  always_comb begin
    fetch = st == S_IF && run;
    jal = st == S_ID && cls == C_JAL;
    jmp = st == S_ID && (cls == C_J || cls == C_JAL || cls == C_JR);
    br = st == S_EX && (cls == C_BEQ || cls == C_BNE);
    br_tk = br && (cls == C_BEQ ? ZF : !ZF);
    exm = st == S_EX || st == S_MEM;
    wb = st == S_WB;
    sw_done = st == S_MEM && cls == C_SW && mem_ready;
    IR_Write = rst_n && fetch;
    PC_Write = rst_n && (fetch || jmp || br_tk);
    Reg_Write = rst_n && (jal || wb);
    Mem_Write = rst_n && st == S_MEM && cls == C_SW;
    retire = rst_n && (jmp || br || sw_done || wb);
    illegal = rst_n && st == S_ILL;
    PC_s = st == S_ID && cls == C_JR ? PC_S_RS : jmp ? PC_S_JMP : br_tk ? PC_S_BR : PC_S_PC4;
    alu_mem_s = jal ? WB_PC4 : wb && cls == C_LW ? WB_MEM : WB_ALU;
    rd_rt_s = jal ? RD_31 : wb && cls != C_R_ALU ? RD_RT : RD_RD;
    ALU_OP = exm ? dec_op : ALU_ADD;
    rt_imm_s = exm && dec_rt_imm;
    imm_s = exm && dec_imm;
    state = st;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= S_IF;
      inst_cnt <= '0;
    end else begin
      inst_cnt <= inst_cnt + CNT_W'(retire);
      case (st)
        S_IF: st <= run ? S_ID : S_IF;
        S_ID: st <= cls == C_ILL ? S_ILL : jmp ? S_IF : S_EX;
        S_EX: st <= cls == C_LW || cls == C_SW ? S_MEM : br ? S_IF : S_WB;
        S_MEM: st <= !mem_ready ? S_MEM : cls == C_SW ? S_IF : S_WB;
        S_WB: st <= S_IF;
        default: st <= S_ILL;
      endcase
    end
  end
endmodule
